// File: rtl/us_stamp_arbiter.sv
// Run controller for the microsecond timer plus a four-channel timestamp capture
// arbiter that presents captured stamps one at a time over a valid/ack handshake.
//
// run state | meaning
// R_IDLE    | timer held cleared, waiting for Start
// R_RUN     | timer counting, events captured
// out state | meaning
// O_SEL     | pick the next pending channel round-robin from ptr
// O_PRES    | stamp presented, waiting for Stamp_Ack
module us_stamp_arbiter #(
   parameter int NCH = 4,
   parameter int TW  = 64
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           Start,
   input  logic           Stop,
   output logic           Tmr_En,
   input  logic [TW-1:0]  Nus,
   input  logic           Ovf,
   input  logic [NCH-1:0] Evt,
   output logic [TW-1:0]  Stamp,
   output logic [1:0]     Stamp_Id,
   output logic           Stamp_Vld,
   input  logic           Stamp_Ack,
   output logic [NCH-1:0] Lost,
   input  logic           Lost_Clr,
   output logic           Err,
   output logic           Busy
);

   typedef enum logic {R_IDLE, R_RUN} run_t;
   typedef enum logic {O_SEL, O_PRES} out_t;

   run_t           run_q, run_d;
   out_t           out_q, out_d;
   logic           err_q, err_d;
   logic [NCH-1:0] pending_q, pending_d;
   logic [NCH-1:0] lost_q, lost_d;
   logic [TW-1:0]  snap_q [NCH];
   logic [TW-1:0]  stamp_q, stamp_d;
   logic [1:0]     id_q, id_d;
   logic           vld_q, vld_d;
   logic [1:0]     ptr_q, ptr_d;

   logic           tmr_en;
   logic [NCH-1:0] acc, load, ovr, clr;
   logic           sel_found;
   logic [1:0]     sel_id, cand;

   assign tmr_en    = (run_q == R_RUN);
   assign Tmr_En    = tmr_en;
   assign Err       = err_q;
   assign Lost      = lost_q;
   assign Stamp     = stamp_q;
   assign Stamp_Id  = id_q;
   assign Stamp_Vld = vld_q;
   assign Busy      = (|pending_q) | vld_q;

   always_comb begin
      run_d = run_q;
      err_d = err_q;
      unique case (run_q)
         R_IDLE: begin
            if (Start && !Stop) begin
               run_d = R_RUN;
               err_d = 1'b0;
            end
         end
         R_RUN: begin
            if (Stop) begin
               run_d = R_IDLE;
            end else if (Ovf) begin
               run_d = R_IDLE;
               err_d = 1'b1;
            end
         end
         default: run_d = R_IDLE;
      endcase
   end

   // Round-robin search; the 2-bit add wraps naturally modulo 4.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = ptr_q;
      cand      = ptr_q;
      for (int j = 0; j < NCH; j++) begin
         cand = ptr_q + 2'(j);
         if (!sel_found && pending_q[cand]) begin
            sel_found = 1'b1;
            sel_id    = cand;
         end
      end
   end

   always_comb begin
      out_d   = out_q;
      stamp_d = stamp_q;
      id_d    = id_q;
      vld_d   = vld_q;
      ptr_d   = ptr_q;
      clr     = '0;
      unique case (out_q)
         O_SEL: begin
            if (sel_found) begin
               stamp_d     = snap_q[sel_id];
               id_d        = sel_id;
               vld_d       = 1'b1;
               clr[sel_id] = 1'b1;
               out_d       = O_PRES;
            end
         end
         O_PRES: begin
            if (Stamp_Ack) begin
               vld_d = 1'b0;
               ptr_d = id_q + 2'd1;
               out_d = O_SEL;
            end
         end
         default: out_d = O_SEL;
      endcase
   end

   // A channel being handed off this cycle can take a fresh capture without overrun.
   always_comb begin
      acc       = Evt & {NCH{tmr_en}};
      load      = acc & (~pending_q | clr);
      ovr       = acc & pending_q & ~clr;
      pending_d = (pending_q & ~clr) | acc;
      lost_d    = (Lost_Clr ? '0 : lost_q) | ovr;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         run_q     <= R_IDLE;
         out_q     <= O_SEL;
         err_q     <= 1'b0;
         pending_q <= '0;
         lost_q    <= '0;
         stamp_q   <= '0;
         id_q      <= '0;
         vld_q     <= 1'b0;
         ptr_q     <= '0;
      end else begin
         run_q     <= run_d;
         out_q     <= out_d;
         err_q     <= err_d;
         pending_q <= pending_d;
         lost_q    <= lost_d;
         stamp_q   <= stamp_d;
         id_q      <= id_d;
         vld_q     <= vld_d;
         ptr_q     <= ptr_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) snap_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load[i]) snap_q[i] <= Nus;
         end
      end
   end

endmodule

// File: tb/tb_us_stamp_arbiter.sv
// Bench for us_stamp_arbiter: a cycle table for the basic handshake and run control,
// then hand sequences with a scoreboard of expected stamps popped on each accepted handshake.
module tb_us_stamp_arbiter;

   logic        CLK = 1'b0;
   logic        RST, Start, Stop, Tmr_En, Ovf, Stamp_Vld, Stamp_Ack, Lost_Clr, Err, Busy;
   logic [63:0] Nus, Stamp;
   logic [3:0]  Evt, Lost;
   logic [1:0]  Stamp_Id;

   us_stamp_arbiter #(.NCH(4), .TW(64)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Tmr_En(Tmr_En),
      .Nus(Nus), .Ovf(Ovf), .Evt(Evt), .Stamp(Stamp), .Stamp_Id(Stamp_Id),
      .Stamp_Vld(Stamp_Vld), .Stamp_Ack(Stamp_Ack), .Lost(Lost),
      .Lost_Clr(Lost_Clr), .Err(Err), .Busy(Busy)
   );

   always #10 CLK = ~CLK;

   typedef struct {
      logic        start, stop, ack;
      logic [3:0]  evt;
      logic [63:0] nus;
      logic        en, vld, busy;
      logic [1:0]  id;
      logic [63:0] stamp;
   } vec_t;

   typedef struct {
      logic [1:0]  id;
      logic [63:0] val;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   auto_ack = 1'b0;

   function automatic vec_t mk(logic st, logic sp, logic ak, logic [3:0] ev, logic [63:0] n,
                               logic en, logic vl, logic bz, logic [1:0] id, logic [63:0] sm);
      vec_t v;
      v.start = st; v.stop = sp; v.ack = ak; v.evt = ev; v.nus = n;
      v.en = en; v.vld = vl; v.busy = bz; v.id = id; v.stamp = sm;
      return v;
   endfunction

   function automatic exp_t mke(logic [1:0] id, logic [63:0] val);
      exp_t e;
      e.id = id; e.val = val;
      return e;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      if (Stamp_Vld && Stamp_Ack) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got id %0d stamp %0h expected no stamp", Stamp_Id, Stamp);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_id", 64'(Stamp_Id), 64'(e.id));
            chk("sb_stamp", Stamp, e.val);
         end
      end
      @(posedge CLK);
      #1;
      if (auto_ack) Stamp_Ack = Stamp_Vld;
   endtask

   task automatic drain(string name);
      for (int k = 0; k < 40 && sb.size() != 0; k++) step();
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic evt_at(logic [3:0] e, logic [63:0] n);
      Evt = e;
      Nus = n;
      step();
      Evt = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      Start = 0; Stop = 0; Evt = '0; Ovf = 0; Lost_Clr = 0; Stamp_Ack = 0; Nus = '0;
      auto_ack = 1'b0;
      sb.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic run_start();
      Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      do_reset();
      chk("rst_tmr_en", 64'(Tmr_En), 64'd0);
      chk("rst_stamp", Stamp, 64'd0);
      chk("rst_id", 64'(Stamp_Id), 64'd0);
      chk("rst_vld", 64'(Stamp_Vld), 64'd0);
      chk("rst_lost", 64'(Lost), 64'd0);
      chk("rst_err", 64'(Err), 64'd0);
      chk("rst_busy", 64'(Busy), 64'd0);

      // Start, capture ch2 at 0x1F4, hold ack low 10 cycles, ack, then start+stop and a stopped event.
      tbl.push_back(mk(1, 0, 0, 4'b0000, 64'h0,   1, 0, 0, 2'd0, 64'h0));
      tbl.push_back(mk(0, 0, 0, 4'b0100, 64'h1F4, 1, 0, 1, 2'd0, 64'h0));
      tbl.push_back(mk(0, 0, 0, 4'b0000, 64'h1F5, 1, 1, 1, 2'd2, 64'h1F4));
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(0, 0, 0, 4'b0000, 64'h1F6 + 64'(i), 1, 1, 1, 2'd2, 64'h1F4));
      tbl.push_back(mk(1, 0, 1, 4'b0000, 64'h200, 1, 0, 0, 2'd2, 64'h1F4));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 64'h201, 0, 0, 0, 2'd2, 64'h1F4));
      tbl.push_back(mk(0, 0, 0, 4'b1000, 64'h0,   0, 0, 0, 2'd2, 64'h1F4));
      tbl.push_back(mk(0, 0, 0, 4'b0000, 64'h0,   0, 0, 0, 2'd2, 64'h1F4));
      sb.push_back(mke(2'd2, 64'h1F4));
      foreach (tbl[i]) begin
         Start = tbl[i].start; Stop = tbl[i].stop; Stamp_Ack = tbl[i].ack;
         Evt = tbl[i].evt; Nus = tbl[i].nus;
         step();
         chk($sformatf("v%0d_tmr_en", i), 64'(Tmr_En), 64'(tbl[i].en));
         chk($sformatf("v%0d_vld", i), 64'(Stamp_Vld), 64'(tbl[i].vld));
         chk($sformatf("v%0d_busy", i), 64'(Busy), 64'(tbl[i].busy));
         chk($sformatf("v%0d_id", i), 64'(Stamp_Id), 64'(tbl[i].id));
         chk($sformatf("v%0d_stamp", i), Stamp, tbl[i].stamp);
         chk($sformatf("v%0d_lost", i), 64'(Lost), 64'd0);
         chk($sformatf("v%0d_err", i), 64'(Err), 64'd0);
      end
      Start = 0; Stop = 0; Stamp_Ack = 0; Evt = '0;
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // All four channels in one cycle, then ch0+ch3 after the pointer wraps.
      do_reset();
      run_start();
      auto_ack = 1'b1;
      for (int c = 0; c < 4; c++) sb.push_back(mke(2'(c), 64'd100));
      evt_at(4'b1111, 64'd100);
      drain("t2_four_drain");
      sb.push_back(mke(2'd0, 64'd200));
      sb.push_back(mke(2'd3, 64'd200));
      evt_at(4'b1001, 64'd200);
      drain("t2_wrap_drain");
      chk("t2_busy", 64'(Busy), 64'd0);

      // Overrun keeps the first capture; Lost is sticky and a same-cycle overrun beats Lost_Clr.
      do_reset();
      run_start();
      evt_at(4'b0001, 64'd5);
      step();
      chk("t3_vld", 64'(Stamp_Vld), 64'd1);
      chk("t3_id0", 64'(Stamp_Id), 64'd0);
      evt_at(4'b0010, 64'd10);
      evt_at(4'b0010, 64'd12);
      chk("t3_lost", 64'(Lost), 64'b0010);
      Lost_Clr = 1'b1;
      evt_at(4'b0010, 64'd13);
      Lost_Clr = 1'b0;
      chk("t3_set_wins", 64'(Lost), 64'b0010);
      sb.push_back(mke(2'd0, 64'd5));
      sb.push_back(mke(2'd1, 64'd10));
      auto_ack = 1'b1;
      drain("t3_drain");
      chk("t3_lost_sticky", 64'(Lost), 64'b0010);
      Lost_Clr = 1'b1;
      step();
      Lost_Clr = 1'b0;
      chk("t3_lost_clr", 64'(Lost), 64'd0);

      // Overflow stops the timer and sets Err, but the pending stamp is still delivered.
      do_reset();
      run_start();
      evt_at(4'b0010, 64'd7);
      Ovf = 1'b1;
      step();
      Ovf = 1'b0;
      chk("t5_tmr_en", 64'(Tmr_En), 64'd0);
      chk("t5_err", 64'(Err), 64'd1);
      chk("t5_vld", 64'(Stamp_Vld), 64'd1);
      sb.push_back(mke(2'd1, 64'd7));
      auto_ack = 1'b1;
      drain("t5_drain");
      chk("t5_err_hold", 64'(Err), 64'd1);
      run_start();
      chk("t5_err_clr", 64'(Err), 64'd0);
      chk("t5_restart", 64'(Tmr_En), 64'd1);

      // Asynchronous reset mid-handshake discards everything in flight.
      do_reset();
      run_start();
      evt_at(4'b0001, 64'd3);
      step();
      evt_at(4'b0110, 64'd4);
      evt_at(4'b0010, 64'd5);
      chk("t6_pre_vld", 64'(Stamp_Vld), 64'd1);
      chk("t6_pre_lost", 64'(Lost), 64'b0010);
      #3;
      RST = 1'b1;
      #1;
      chk("t6_vld", 64'(Stamp_Vld), 64'd0);
      chk("t6_busy", 64'(Busy), 64'd0);
      chk("t6_tmr_en", 64'(Tmr_En), 64'd0);
      chk("t6_lost", 64'(Lost), 64'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (Stamp_Vld || Busy) seen++;
      end
      chk("t6_no_stamp", 64'(seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/us_stamp_arbiter.md
Name: us_stamp_arbiter

Overview:
Run controller and timestamp-capture arbiter for the 64-bit microsecond timer. It drives the timer enable from start/stop commands and handles timer overflow. It latches the current Nus value for up to four asynchronous-in-time event sources (sensor data-ready strobes). It hands the captured stamps one at a time to a single consumer using round-robin arbitration and a valid/ack handshake.

Parameters:
NCH, 4, number of event channels (fixed at 4; channel ID is 2 bits)
TW, 64, timestamp width; must match the timer's Nus width

Ports:
CLK  in  1  system clock (50 MHz)
RST  in  1  asynchronous active-high reset
Start  in  1  single-cycle run command
Stop  in  1  single-cycle halt command
Tmr_En  out  1  enable to the us timer; timer clears its count when low
Nus  in  TW  current timer count
Ovf  in  1  timer overflow flag
Evt  in  NCH  per-channel event pulses, synchronous to CLK, one cycle each
Stamp  out  TW  timestamp being presented
Stamp_Id  out  2  channel of the presented stamp
Stamp_Vld  out  1  Stamp/Stamp_Id valid
Stamp_Ack  in  1  consumer accepts the stamp
Lost  out  NCH  sticky per-channel overrun flags
Lost_Clr  in  1  clears all Lost bits
Err  out  1  sticky overflow-stop flag
Busy  out  1  high when any capture is pending or Stamp_Vld is high

Behaviour:
- Reset (async, RST=1): Tmr_En=0, Stamp=0, Stamp_Id=0, Stamp_Vld=0, Lost=0, Err=0, Busy=0. All pending bits and snapshot registers are cleared. Round-robin pointer is set to 0. Both FSMs go to their idle state.
- Run FSM (states IDLE, RUN). Tmr_En is a registered output equal to (state==RUN).
  - IDLE: Start -> RUN, and Err <= 0.
  - RUN: Stop -> IDLE. Ovf=1 -> IDLE with Err <= 1.
  - Start and Stop in the same cycle: Stop wins (stays in, or goes to, IDLE).
  - Start while already in RUN: ignored, count not disturbed.
- Capture, per channel i. An event is accepted only when Evt[i]=1 and Tmr_En=1; events with Tmr_En=0 are ignored with no Lost effect.
  - pending[i]=0 (or being cleared this cycle by the selector): snap[i] <= Nus sampled in the Evt cycle, and pending[i] <= 1.
  - pending[i]=1 and not being cleared this cycle: Lost[i] <= 1. snap[i] is unchanged, so the first event is kept.
  - Lost_Clr clears Lost. If Lost_Clr and a new overrun occur in the same cycle, the set wins.
- Output FSM (states OSEL, OPRES).
  - OSEL: if any pending bit is set, choose the first pending channel searching upward from ptr, modulo 4. On the clock edge: Stamp <= snap[k], Stamp_Id <= k, Stamp_Vld <= 1, pending[k] <= 0, then go to OPRES.
  - OPRES: Stamp, Stamp_Id and Stamp_Vld are held stable until Stamp_Ack=1. On ack: Stamp_Vld <= 0, ptr <= k+1 (mod 4), go to OSEL.
  - Stamp_Ack while Stamp_Vld=0 is ignored.
- Latency: an Evt at edge t makes pending visible at t+1, and Stamp_Vld rises at t+2 at the earliest.
  - Maximum throughput is one stamp per 2 cycles (ack cycle, then select cycle).
- Stop and Ovf do not flush anything: pending stamps are still delivered after the timer halts. Snapshots keep the pre-stop values.
- Busy = |pending | Stamp_Vld (combinational from registers).
- Reset mid-handshake: Stamp_Vld drops immediately (async). The in-flight stamp and all pending captures are discarded.

Test Plan:
1. Start, then Evt[2] pulse in the cycle Nus=0x1F4 -> 2 cycles later Stamp=0x1F4, Stamp_Id=2, Stamp_Vld=1. Values are held while Ack is low for 10 cycles; Vld drops the cycle after Ack.
2. After reset, Evt=4'b1111 in one cycle at Nus=100 -> four stamps of value 100 with Stamp_Id 0,1,2,3, each acked immediately. Then Evt[0] and Evt[3] together -> Id 0 first (ptr wrapped to 0), then 3.
3. Hold Ack low. Evt[0] at Nus=5 is presented. Evt[1] at Nus=10, then Evt[1] at Nus=12 -> Lost=4'b0010. After ack, the ch1 stamp is 10. Lost_Clr -> Lost=0.
4. In RUN, Start and Stop in the same cycle -> Tmr_En=0 the next cycle. Evt[3] while stopped -> no stamp, Lost unchanged, Busy=0.
5. In RUN with Evt[1] pending, pulse Ovf -> Tmr_En=0 and Err=1 the next cycle; the ch1 stamp is still delivered. A later Start -> Err=0 and Tmr_En=1.
6. With Stamp_Vld=1 and two channels pending, assert RST -> Stamp_Vld, Busy, Tmr_En and Lost are all 0 immediately. After release, no stamps appear without new events.
